// File: rtl/prescaled_counter_pkg.sv
// ---------------------------------------------------------------------------
// prescaled_counter_pkg
// Shared constants and helpers for the prescaled up/down counter slice.
//   CLK_HZ     : system clock frequency (PYNQ-Z2, 125 MHz)
//   MODE_WRAP  : counter wraps modulo 2^WIDTH at the terminal value
//   MODE_SAT   : counter holds at the terminal value
//   pre_w(div) : width of the prescaler register for a given divide ratio
// ---------------------------------------------------------------------------
package prescaled_counter_pkg;

    localparam int CLK_HZ    = 125_000_000;
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // max(1, $clog2(div)): a divide-by-1 or divide-by-2 prescaler still needs
    // one bit so the register never collapses to zero width.
    function automatic int pre_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/prescaler_tick.sv
// ---------------------------------------------------------------------------
// prescaler_tick
// Free-running divide-by-DIV prescaler that issues a one-cycle enable strobe
// instead of a derived clock. The strobe is combinational so the consumer
// acts on the same edge that wraps the prescaler.
//   clk     in  : system clock
//   rst     in  : asynchronous reset, active-high (prescaler -> 0)
//   en      in  : 1 = prescaler advances, 0 = prescaler holds
//   clr_pre in  : synchronous restart of the prescale period
//   strobe  out : high while en=1 and the prescaler sits on its last count
// ---------------------------------------------------------------------------
module prescaler_tick
    import prescaled_counter_pkg::*;
#(
    parameter int DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr_pre,
    output logic strobe
);

    localparam int             PW   = pre_w(DIV);
    localparam logic [PW-1:0]  LAST = PW'(DIV - 1);

    logic [PW-1:0] pre;

    assign strobe = en && (pre == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (clr_pre) begin
            pre <= '0;
        end else if (en) begin
            if (strobe) begin
                pre <= '0;
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

endmodule

// File: rtl/prescaled_updown_counter.sv
// ---------------------------------------------------------------------------
// prescaled_updown_counter
// Up/down counter advanced by an internal prescaler strobe; everything runs on
// clk. Wraps or saturates at the terminal value depending on MODE_SAT.
// Optional feature macro: CNT_LOAD_EN adds the load/load_val parallel load.
//   clk      in  : system clock, 125 MHz
//   rst      in  : asynchronous reset, active-high
//   en       in  : 1 = prescaler runs, 0 = prescaler and count frozen
//   dir      in  : 1 = count up, 0 = count down (sampled at the strobe)
//   clr      in  : synchronous clear to INIT, restarts the prescale period
//   load     in  : synchronous parallel load (CNT_LOAD_EN only)
//   load_val in  : value for load (CNT_LOAD_EN only)
//   count    out : current count
//   tick     out : one-cycle pulse in the cycle after the count stepped
//   tc       out : one-cycle terminal-count pulse, aligned with tick
// ---------------------------------------------------------------------------
module prescaled_updown_counter
    import prescaled_counter_pkg::CLK_HZ, prescaled_counter_pkg::MODE_WRAP;
#(
    parameter int               WIDTH    = 4,
    parameter int               DIV      = CLK_HZ / 10,
    parameter logic [WIDTH-1:0] INIT     = WIDTH'(4'hF),
    parameter int               MODE_SAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
`ifdef CNT_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    localparam bit SATURATE = (MODE_SAT != MODE_WRAP);

    logic             strobe;
    logic             clr_pre;
    logic             do_load;
    logic [WIDTH-1:0] load_data;
    logic             at_terminal;
    logic [WIDTH-1:0] next_count;

`ifdef CNT_LOAD_EN
    assign do_load   = load;
    assign load_data = load_val;
`else
    assign do_load   = 1'b0;
    assign load_data = INIT;
`endif

    // A load restarts the prescale period just like a clear does.
    assign clr_pre = clr | do_load;

    prescaler_tick #(
        .DIV     (DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr_pre (clr_pre),
        .strobe  (strobe)
    );

    // NOTE: every output of a combinational block gets a default first so no
    // path through it can leave a latch behind.
    always_comb begin
        at_terminal = dir ? (count == '1) : (count == '0);
        next_count  = count;
        if (!(SATURATE && at_terminal)) begin
            next_count = dir ? (count + WIDTH'(1)) : (count - WIDTH'(1));
        end
    end

    // Priority: rst > clr > load > strobe. A strobe coinciding with clr or
    // load is dropped, so tick/tc stay low on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= INIT;
            tick  <= 1'b0;
            tc    <= 1'b0;
        end else if (clr) begin
            count <= INIT;
            tick  <= 1'b0;
            tc    <= 1'b0;
        end else if (do_load) begin
            count <= load_data;
            tick  <= 1'b0;
            tc    <= 1'b0;
        end else begin
            tick <= strobe;
            tc   <= strobe && at_terminal;
            if (strobe) begin
                count <= next_count;
            end
        end
    end

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_prescaled_updown_counter
// Two instances (wrap and saturate) share one stimulus stream. A cycle model
// of the counter pushes the expected {count,tick,tc} of both instances into a
// queue before each clock edge; each scenario task pops and compares after
// the edge, and adds directed checks for timing and boundary behaviour.
// ---------------------------------------------------------------------------
module tb_prescaled_updown_counter;

    localparam int         WIDTH = 4;
    localparam int         DIV   = 4;
    localparam logic [3:0] INIT  = 4'hF;

    logic       clk;
    logic       rst;
    logic       en;
    logic       dir;
    logic       clr;
`ifdef CNT_LOAD_EN
    logic       load;
    logic [3:0] load_val;
`endif
    logic [3:0] count_w, count_s;
    logic       tick_w, tc_w, tick_s, tc_s;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state and scoreboard
    int         m_pre;
    logic [3:0] m_cnt [2];
    logic       m_tick;
    logic       m_tc  [2];
    logic [11:0] sb_q [$];

    prescaled_updown_counter #(
        .WIDTH(WIDTH), .DIV(DIV), .INIT(INIT), .MODE_SAT(0)
    ) u_wrap (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr),
`ifdef CNT_LOAD_EN
        .load(load), .load_val(load_val),
`endif
        .count(count_w), .tick(tick_w), .tc(tc_w)
    );

    prescaled_updown_counter #(
        .WIDTH(WIDTH), .DIV(DIV), .INIT(INIT), .MODE_SAT(1)
    ) u_sat (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr),
`ifdef CNT_LOAD_EN
        .load(load), .load_val(load_val),
`endif
        .count(count_s), .tick(tick_s), .tc(tc_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] obs();
        return {count_w, tick_w, tc_w, count_s, tick_s, tc_s};
    endfunction

    function automatic void model_reset();
        m_pre  = 0;
        m_tick = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = INIT;
            m_tc[i]  = 1'b0;
        end
        sb_q.delete();
    endfunction

    // Predicts the state after the coming edge from the inputs now applied.
    // Index 0 = wrap instance, index 1 = saturate instance.
    function automatic void model_edge();
        logic       ld;
        logic [3:0] lv;
        logic       term;
        ld = 1'b0;
        lv = INIT;
`ifdef CNT_LOAD_EN
        ld = load;
        lv = load_val;
`endif
        if (clr || ld) begin
            m_pre  = 0;
            m_tick = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = clr ? INIT : lv;
                m_tc[i]  = 1'b0;
            end
        end else if (en && (m_pre == DIV - 1)) begin
            m_pre  = 0;
            m_tick = 1'b1;
            for (int i = 0; i < 2; i++) begin
                term    = dir ? (m_cnt[i] == 4'hF) : (m_cnt[i] == 4'h0);
                m_tc[i] = term;
                if (!(term && i == 1)) begin
                    m_cnt[i] = dir ? m_cnt[i] + 4'd1 : m_cnt[i] - 4'd1;
                end
            end
        end else begin
            if (en) m_pre = m_pre + 1;
            m_tick = 1'b0;
            for (int i = 0; i < 2; i++) m_tc[i] = 1'b0;
        end
        sb_q.push_back({m_cnt[0], m_tick, m_tc[0], m_cnt[1], m_tick, m_tc[1]});
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        en = 1'b0; dir = 1'b0; clr = 1'b0; rst = 1'b0;
`ifdef CNT_LOAD_EN
        load = 1'b0; load_val = 4'h0;
`endif
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== {4'hF, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", obs(), {4'hF, 2'b00, 4'hF, 2'b00});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_count_down();
        logic [11:0] got, exp;
        int first = -1, ticks = 0, tcw = 0, tcs = 0;
        en = 1'b1; dir = 1'b0;
        for (int c = 1; c <= 17 * DIV; c++) begin
            step();
            got = obs(); exp = sb_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL down c%0d: got %h want %h", c, got, exp);
            end
            if (tick_w) begin ticks++; if (first < 0) first = c; end
            if (tc_w) tcw++;
            if (tc_s) tcs++;
        end
        n_cmp++;
        if (first !== 4) begin n_bad++; $display("FAIL down_first_step: got %0d want 4", first); end
        n_cmp++;
        if (ticks !== 17) begin n_bad++; $display("FAIL down_ticks: got %0d want 17", ticks); end
        n_cmp++;
        if (tcw !== 1) begin n_bad++; $display("FAIL down_tc_wrap: got %0d want 1", tcw); end
        n_cmp++;
        if (tcs !== 2) begin n_bad++; $display("FAIL down_tc_sat: got %0d want 2", tcs); end
    endtask

    task automatic test_count_up();
        logic [11:0] got, exp;
        int tcw = 0, last_tick = 0, gap = 0;
        dir = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (c == 11) dir = 1'b0;     // flip mid-period, pre is 2 here
            step();
            got = obs(); exp = sb_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL up c%0d: got %h want %h", c, got, exp);
            end
            if (tick_w) begin gap = c - last_tick; last_tick = c; end
            if (tc_w && c <= 8) tcw++;
            if (c == 8) begin
                n_cmp++;
                if (count_w !== 4'h0) begin n_bad++; $display("FAIL up_wrap: got %h want 0", count_w); end
            end
        end
        n_cmp++;
        if (tcw !== 1) begin n_bad++; $display("FAIL up_tc: got %0d want 1", tcw); end
        n_cmp++;
        if (gap !== 4 || count_w !== 4'hF) begin
            n_bad++;
            $display("FAIL dir_flip: gap %0d count %h want gap 4 count f", gap, count_w);
        end
    endtask

    task automatic test_saturate();
        logic [11:0] got, exp;
        int tcs = 0, ticks = 0;
        clr = 1'b1; step(); void'(sb_q.pop_front()); clr = 1'b0;
        n_cmp++;
        if (count_s !== 4'hF) begin n_bad++; $display("FAIL sat_clr: got %h want f", count_s); end
        dir = 1'b0;
        for (int c = 1; c <= 20 * DIV; c++) begin
            step();
            got = obs(); exp = sb_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL sat c%0d: got %h want %h", c, got, exp);
            end
            if (tick_s) ticks++;
            if (tc_s) tcs++;
        end
        n_cmp++;
        if (count_s !== 4'h0 || tcs !== 5 || ticks !== 20) begin
            n_bad++;
            $display("FAIL sat_hold: count %h tc %0d ticks %0d want 0/5/20", count_s, tcs, ticks);
        end
    endtask

    task automatic test_freeze();
        logic [11:0] got, exp;
        logic [3:0]  held;
        clr = 1'b1; step(); void'(sb_q.pop_front()); clr = 1'b0;
        en = 1'b1; dir = 1'b0;
        step(); void'(sb_q.pop_front());
        step(); void'(sb_q.pop_front());   // prescaler now at 2
        held = count_w;
        en = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            got = obs(); exp = sb_q.pop_front(); n_cmp++;
            if (got !== exp || count_w !== held || tick_w || tc_w) begin
                n_bad++;
                $display("FAIL freeze c%0d: got %h want %h", c, got, exp);
            end
        end
        en = 1'b1;
        // One remaining prescale cycle, then the step on the following edge.
        for (int c = 1; c <= 2; c++) begin
            step();
            got = obs(); exp = sb_q.pop_front(); n_cmp++;
            if (got !== exp || tick_w !== (c == 2)) begin
                n_bad++;
                $display("FAIL resume c%0d: got %h want %h", c, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] got, exp;
        int first = -1;
        clr = 1'b1; step(); void'(sb_q.pop_front()); clr = 1'b0;
        en = 1'b1; dir = 1'b0;
        repeat (6) begin step(); void'(sb_q.pop_front()); end   // count E, pre 2
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== {4'hF, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL async_rst: got %h want %h", obs(), {4'hF, 2'b00, 4'hF, 2'b00});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int c = 1; c <= DIV; c++) begin
            step();
            got = obs(); exp = sb_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL post_rst c%0d: got %h want %h", c, got, exp);
            end
            if (tick_w && first < 0) first = c;
        end
        n_cmp++;
        if (first !== DIV) begin n_bad++; $display("FAIL post_rst_first: got %0d want %0d", first, DIV); end
        repeat (DIV - 1) begin step(); void'(sb_q.pop_front()); end  // strobe pending
        clr = 1'b1;
        step();
        got = obs(); exp = sb_q.pop_front(); n_cmp++;
        if (got !== exp || count_w !== 4'hF || tick_w !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_on_strobe: got %h want %h", got, exp);
        end
        clr = 1'b0;
    endtask

`ifdef CNT_LOAD_EN
    task automatic test_load();
        logic [11:0] got, exp;
        int first = -1;
        clr = 1'b1; step(); void'(sb_q.pop_front()); clr = 1'b0;
        en = 1'b1; dir = 1'b0;
        repeat (DIV - 1) begin step(); void'(sb_q.pop_front()); end  // strobe pending
        load = 1'b1; load_val = 4'h9;
        step();
        got = obs(); exp = sb_q.pop_front(); n_cmp++;
        if (got !== exp || count_w !== 4'h9 || tick_w !== 1'b0) begin
            n_bad++;
            $display("FAIL load_on_strobe: got %h want %h", got, exp);
        end
        load = 1'b0;
        for (int c = 1; c <= DIV; c++) begin
            step();
            got = obs(); exp = sb_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL post_load c%0d: got %h want %h", c, got, exp);
            end
            if (tick_w && first < 0) first = c;
        end
        n_cmp++;
        if (first !== DIV || count_w !== 4'h8) begin
            n_bad++;
            $display("FAIL load_next_step: first %0d count %h want %0d/8", first, count_w, DIV);
        end
        clr = 1'b1; load = 1'b1; load_val = 4'h5;
        step();
        got = obs(); exp = sb_q.pop_front(); n_cmp++;
        if (got !== exp || count_w !== 4'hF) begin
            n_bad++;
            $display("FAIL clr_over_load: got %h want %h", got, exp);
        end
        clr = 1'b0; load = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_count_down();
        test_count_up();
        test_saturate();
        test_freeze();
        test_async_reset();
`ifdef CNT_LOAD_EN
        test_load();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
